// File: rtl/di_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// di_wb_port_arbiter
//
// Merges the two issue-2 writeback sources onto regfile write port b2.
//   Source A : issue-2 ALU result. Fire-and-forget, it always wins when valid.
//   Source B : multicycle/LSU result. Uses a valid/ready handshake.
// The winning write is registered (one cycle of latency). While it is in
// flight it is bypassed onto read ports a2/b2. When B has been denied
// MAX_WAIT times in a row, the FSM enters ARB_STALL and asks issue-2 to stop
// producing A results until B gets through.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   a_valid_i/a_addr_i/a_data_i      source A write request
//   b_valid_i/b_ready_o/b_addr_i/b_data_i
//                                    source B write request and handshake
//   stall_a_o                        high while in ARB_STALL
//   waddr_b2_o/wdata_b2_o/we_b2_o    registered regfile write port
//   raddr_a2_i/rdata_a2_i/fwd_rdata_a2_o
//                                    read port a2 with bypass of the in-flight write
//   raddr_b2_i/rdata_b2_i/fwd_rdata_b2_o
//                                    read port b2 with bypass of the in-flight write
//
// Optional feature, macro DI_WB_ARB_PERF_CNT_EN
//   Adds the saturating counters perf_conflict_o, perf_drop_o and perf_stall_o,
//   each PERF_CNT_W bits wide.
// -----------------------------------------------------------------------------
module di_wb_port_arbiter #(
  parameter int MAX_WAIT   = 4,
  parameter int PERF_CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid_i,
  input  logic [4:0]  a_addr_i,
  input  logic [31:0] a_data_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  input  logic [4:0]  b_addr_i,
  input  logic [31:0] b_data_i,
  output logic        stall_a_o,
  output logic [4:0]  waddr_b2_o,
  output logic [31:0] wdata_b2_o,
  output logic        we_b2_o,
  input  logic [4:0]  raddr_a2_i,
  input  logic [31:0] rdata_a2_i,
  output logic [31:0] fwd_rdata_a2_o,
  input  logic [4:0]  raddr_b2_i,
  input  logic [31:0] rdata_b2_i,
  output logic [31:0] fwd_rdata_b2_o
`ifdef DI_WB_ARB_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_conflict_o,
  output logic [PERF_CNT_W-1:0] perf_drop_o,
  output logic [PERF_CNT_W-1:0] perf_stall_o
`endif
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15 || PERF_CNT_W < 1) begin : g_param_check
    $error("di_wb_port_arbiter: MAX_WAIT must be 1..15 and PERF_CNT_W >= 1");
  end

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_STALL  = 1'b1
  } arb_state_e;

  arb_state_e  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        we_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  logic        in_stall;
  logic        same_addr;
  logic        b_accept;
  logic        b_deny;
  logic        win_valid;
  logic [4:0]  win_addr;
  logic [31:0] win_data;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign in_stall  = (state_q == ARB_STALL);
  assign same_addr = a_valid_i && b_valid_i && (a_addr_i == b_addr_i) && (a_addr_i != 5'd0);

  // B is taken when A is idle. It is also taken in NORMAL when A overwrites
  // the same register: A is younger, so B's result is dead and is completed
  // and dropped. In STALL a lagging A keeps B waiting instead of dropping it,
  // which keeps the exit path out of STALL simple. Ready is forced low during
  // reset so no handshake completes into a write that reset discards.
  assign b_accept = rst_n && b_valid_i && (!a_valid_i || (!in_stall && same_addr));
  assign b_deny   = b_valid_i && !b_accept;

  assign win_valid = a_valid_i || b_accept;
  assign win_addr  = a_valid_i ? a_addr_i : b_addr_i;
  assign win_data  = a_valid_i ? a_data_i : b_data_i;

  assign b_ready_o = b_accept;
  assign stall_a_o = in_stall;

  // ---------------------------------------------------------------------------
  // Anti-starvation FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (state_q == ARB_NORMAL) begin
      if (b_deny) begin
        wait_cnt_d = wait_cnt_q + 4'd1;
        if (wait_cnt_d == MAX_WAIT_C) state_d = ARB_STALL;
      end else begin
        wait_cnt_d = 4'd0;
      end
    end else begin
      // Leave STALL once B drains or goes away; a lagging A holds us here.
      if (!b_valid_i || b_accept) begin
        state_d    = ARB_NORMAL;
        wait_cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_NORMAL;
      wait_cnt_q <= 4'd0;
      we_q       <= 1'b0;
      waddr_q    <= 5'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      // Writes to x0 complete their handshake but never enable the port.
      we_q       <= win_valid && (win_addr != 5'd0);
      if (win_valid) begin
        waddr_q <= win_addr;
        wdata_q <= win_data;
      end
    end
  end

  assign we_b2_o    = we_q;
  assign waddr_b2_o = waddr_q;
  assign wdata_b2_o = wdata_q;

  // ---------------------------------------------------------------------------
  // Bypass of the in-flight write (commits at the next edge)
  // ---------------------------------------------------------------------------
  assign fwd_rdata_a2_o = (we_q && (raddr_a2_i == waddr_q) && (raddr_a2_i != 5'd0))
                          ? wdata_q : rdata_a2_i;
  assign fwd_rdata_b2_o = (we_q && (raddr_b2_i == waddr_q) && (raddr_b2_i != 5'd0))
                          ? wdata_q : rdata_b2_i;

`ifdef DI_WB_ARB_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic                  b_drop;
  logic [PERF_CNT_W-1:0] perf_conflict_q, perf_drop_q, perf_stall_q;

  assign b_drop = b_accept && a_valid_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_conflict_q <= '0;
      perf_drop_q     <= '0;
      perf_stall_q    <= '0;
    end else begin
      if (b_deny && !(&perf_conflict_q)) perf_conflict_q <= perf_conflict_q + 1'b1;
      if (b_drop && !(&perf_drop_q))     perf_drop_q     <= perf_drop_q + 1'b1;
      if (in_stall && !(&perf_stall_q))  perf_stall_q    <= perf_stall_q + 1'b1;
    end
  end

  assign perf_conflict_o = perf_conflict_q;
  assign perf_drop_o     = perf_drop_q;
  assign perf_stall_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_di_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for di_wb_port_arbiter: directed scenarios followed by a
// randomized run checked against a cycle-level reference model of the
// arbitration rules.
// -----------------------------------------------------------------------------
module tb_di_wb_port_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int PCW      = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid_i;
  logic [4:0]  a_addr_i;
  logic [31:0] a_data_i;
  logic        b_valid_i;
  logic        b_ready_o;
  logic [4:0]  b_addr_i;
  logic [31:0] b_data_i;
  logic        stall_a_o;
  logic [4:0]  waddr_b2_o;
  logic [31:0] wdata_b2_o;
  logic        we_b2_o;
  logic [4:0]  raddr_a2_i, raddr_b2_i;
  logic [31:0] rdata_a2_i, rdata_b2_i;
  logic [31:0] fwd_rdata_a2_o, fwd_rdata_b2_o;
`ifdef DI_WB_ARB_PERF_CNT_EN
  logic [PCW-1:0] perf_conflict_o, perf_drop_o, perf_stall_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: expected write-port register and arbitration history.
  bit          m_stall;
  int          m_streak;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  di_wb_port_arbiter #(.MAX_WAIT(MAX_WAIT), .PERF_CNT_W(PCW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
    .stall_a_o(stall_a_o),
    .waddr_b2_o(waddr_b2_o), .wdata_b2_o(wdata_b2_o), .we_b2_o(we_b2_o),
    .raddr_a2_i(raddr_a2_i), .rdata_a2_i(rdata_a2_i), .fwd_rdata_a2_o(fwd_rdata_a2_o),
    .raddr_b2_i(raddr_b2_i), .rdata_b2_i(rdata_b2_i), .fwd_rdata_b2_o(fwd_rdata_b2_o)
`ifdef DI_WB_ARB_PERF_CNT_EN
    ,
    .perf_conflict_o(perf_conflict_o), .perf_drop_o(perf_drop_o), .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid_i = av; a_addr_i = aa; a_data_i = ad;
    b_valid_i = bv; b_addr_i = ba; b_data_i = bd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    m_stall = 0; m_streak = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
    tick(); tick(); #1;
    n_chk += 3;
    if (we_b2_o !== 1'b0)   begin n_fail++; $display("FAIL reset_we: got %b want 0", we_b2_o); end
    if (b_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", b_ready_o); end
    if (stall_a_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_a_o); end
    rst_n = 1'b1;
    drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    n_chk += 2;
    if (we_b2_o !== 1'b1)    begin n_fail++; $display("FAIL reset_first_we: got %b want 1", we_b2_o); end
    if (waddr_b2_o !== 5'd6) begin n_fail++; $display("FAIL reset_first_addr: got %0d want 6", waddr_b2_o); end
    tick();
  endtask

  task automatic test_a_only();
    do_reset();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    raddr_a2_i = 5'd5; rdata_a2_i = 32'h12345678;
    raddr_b2_i = 5'd6; rdata_b2_i = 32'h0BADF00D;
    #1;
    n_chk += 5;
    if (we_b2_o !== 1'b1)             begin n_fail++; $display("FAIL aonly_we: got %b want 1", we_b2_o); end
    if (waddr_b2_o !== 5'd5)          begin n_fail++; $display("FAIL aonly_addr: got %0d want 5", waddr_b2_o); end
    if (wdata_b2_o !== 32'hDEADBEEF)  begin n_fail++; $display("FAIL aonly_data: got %h want deadbeef", wdata_b2_o); end
    if (fwd_rdata_a2_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL aonly_fwd_a: got %h want deadbeef", fwd_rdata_a2_o); end
    if (fwd_rdata_b2_o !== 32'h0BADF00D) begin n_fail++; $display("FAIL aonly_fwd_b_miss: got %h want 0badf00d", fwd_rdata_b2_o); end
    tick();
  endtask

  task automatic test_conflict();
    do_reset();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    #1;
    n_chk++;
    if (b_ready_o !== 1'b0) begin n_fail++; $display("FAIL conflict_deny: got %b want 0", b_ready_o); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    #1;
    n_chk += 2;
    if (b_ready_o !== 1'b1)  begin n_fail++; $display("FAIL conflict_accept: got %b want 1", b_ready_o); end
    if (waddr_b2_o !== 5'd3) begin n_fail++; $display("FAIL conflict_a_addr: got %0d want 3", waddr_b2_o); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    n_chk += 3;
    if (we_b2_o !== 1'b1)     begin n_fail++; $display("FAIL conflict_b_we: got %b want 1", we_b2_o); end
    if (waddr_b2_o !== 5'd7)  begin n_fail++; $display("FAIL conflict_b_addr: got %0d want 7", waddr_b2_o); end
    if (wdata_b2_o !== 32'h77) begin n_fail++; $display("FAIL conflict_b_data: got %h want 77", wdata_b2_o); end
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    for (int i = 1; i <= MAX_WAIT; i++) begin
      drive(1'b1, 5'd1, 32'(i), 1'b1, 5'd2, 32'h22);
      #1;
      n_chk += 2;
      if (b_ready_o !== 1'b0) begin n_fail++; $display("FAIL starve_deny_c%0d: got %b want 0", i, b_ready_o); end
      if (stall_a_o !== 1'b0) begin n_fail++; $display("FAIL starve_nostall_c%0d: got %b want 0", i, stall_a_o); end
      tick();
    end
    // Cycle MAX_WAIT+1: stall raised, A lagging still wins.
    drive(1'b1, 5'd1, 32'h55, 1'b1, 5'd2, 32'h22);
    #1;
    n_chk += 2;
    if (stall_a_o !== 1'b1) begin n_fail++; $display("FAIL starve_stall: got %b want 1", stall_a_o); end
    if (b_ready_o !== 1'b0) begin n_fail++; $display("FAIL starve_held: got %b want 0", b_ready_o); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h22);
    #1;
    n_chk += 3;
    if (stall_a_o !== 1'b1)    begin n_fail++; $display("FAIL starve_stall2: got %b want 1", stall_a_o); end
    if (b_ready_o !== 1'b1)    begin n_fail++; $display("FAIL starve_accept: got %b want 1", b_ready_o); end
    if (wdata_b2_o !== 32'h55) begin n_fail++; $display("FAIL starve_lag_a: got %h want 55", wdata_b2_o); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    n_chk += 2;
    if (stall_a_o !== 1'b0)  begin n_fail++; $display("FAIL starve_release: got %b want 0", stall_a_o); end
    if (waddr_b2_o !== 5'd2) begin n_fail++; $display("FAIL starve_b_addr: got %0d want 2", waddr_b2_o); end
    tick();
  endtask

  task automatic test_same_addr();
    do_reset();
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
    #1;
    n_chk++;
    if (b_ready_o !== 1'b1) begin n_fail++; $display("FAIL same_ready: got %b want 1", b_ready_o); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    n_chk += 2;
    if (waddr_b2_o !== 5'd9)  begin n_fail++; $display("FAIL same_addr: got %0d want 9", waddr_b2_o); end
    if (wdata_b2_o !== 32'h1) begin n_fail++; $display("FAIL same_data: got %h want 1", wdata_b2_o); end
`ifdef DI_WB_ARB_PERF_CNT_EN
    n_chk++;
    if (perf_drop_o !== PCW'(1)) begin n_fail++; $display("FAIL same_perf_drop: got %0d want 1", perf_drop_o); end
`endif
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    #1;
    n_chk++;
    if (b_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b want 1", b_ready_o); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    raddr_b2_i = 5'd0; rdata_b2_i = 32'hCAFE;
    #1;
    n_chk += 2;
    if (we_b2_o !== 1'b0)            begin n_fail++; $display("FAIL x0_we: got %b want 0", we_b2_o); end
    if (fwd_rdata_b2_o !== 32'hCAFE) begin n_fail++; $display("FAIL x0_fwd_b: got %h want cafe", fwd_rdata_b2_o); end
    tick();
  endtask

  task automatic test_random();
    bit          b_pend;
    logic [4:0]  pa;
    logic [31:0] pd;
    bit          e_rdy, win, denied;
    logic [4:0]  wa;
    logic [31:0] wd, e_fa, e_fb;
    do_reset();
    b_pend = 0; pa = '0; pd = '0;
    for (int c = 0; c < 800; c++) begin
      rst_n     = ($urandom_range(99) >= 2);
      a_valid_i = ($urandom_range(99) < 65);
      a_addr_i  = 5'($urandom);
      a_data_i  = $urandom;
      if (!b_pend && $urandom_range(99) < 50) begin
        b_pend = 1; pa = 5'($urandom); pd = $urandom;
      end else if (b_pend && $urandom_range(99) < 4) begin
        b_pend = 0;
      end
      b_valid_i = b_pend && rst_n; b_addr_i = pa; b_data_i = pd;
      if (b_valid_i && pa != 5'd0 && $urandom_range(99) < 15) a_addr_i = pa;
      if (a_valid_i && b_valid_i && a_addr_i == 5'd0 && pa == 5'd0) a_addr_i = 5'd1;
      raddr_a2_i = $urandom_range(1) ? m_waddr : 5'($urandom);
      raddr_b2_i = $urandom_range(1) ? m_waddr : 5'($urandom);
      rdata_a2_i = $urandom; rdata_b2_i = $urandom;

      // A always wins; B is taken if A is idle, or dropped under a same-register
      // overwrite outside STALL.
      e_rdy = b_valid_i && (!a_valid_i ||
              (!m_stall && a_addr_i == b_addr_i && a_addr_i != 5'd0));
      e_fa = (m_we && raddr_a2_i == m_waddr && raddr_a2_i != 5'd0) ? m_wdata : rdata_a2_i;
      e_fb = (m_we && raddr_b2_i == m_waddr && raddr_b2_i != 5'd0) ? m_wdata : rdata_b2_i;
      #1;
      n_chk += 4;
      if (stall_a_o !== m_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall_a_o, m_stall); end
      if (we_b2_o !== m_we)      begin n_fail++; $display("FAIL rnd_we c%0d: got %b want %b", c, we_b2_o, m_we); end
      if (fwd_rdata_a2_o !== e_fa) begin n_fail++; $display("FAIL rnd_fwd_a c%0d: got %h want %h", c, fwd_rdata_a2_o, e_fa); end
      if (fwd_rdata_b2_o !== e_fb) begin n_fail++; $display("FAIL rnd_fwd_b c%0d: got %h want %h", c, fwd_rdata_b2_o, e_fb); end
      if (m_we) begin
        n_chk += 2;
        if (waddr_b2_o !== m_waddr) begin n_fail++; $display("FAIL rnd_waddr c%0d: got %0d want %0d", c, waddr_b2_o, m_waddr); end
        if (wdata_b2_o !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, wdata_b2_o, m_wdata); end
      end
      if (rst_n) begin
        n_chk++;
        if (b_ready_o !== e_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, b_ready_o, e_rdy); end
      end

      if (!rst_n) begin
        m_stall = 0; m_streak = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
      end else begin
        win = a_valid_i || e_rdy;
        wa  = a_valid_i ? a_addr_i : b_addr_i;
        wd  = a_valid_i ? a_data_i : b_data_i;
        m_we = win && wa != 5'd0;
        if (win) begin m_waddr = wa; m_wdata = wd; end
        denied = b_valid_i && !e_rdy;
        if (!m_stall) begin
          if (denied) begin
            m_streak++;
            if (m_streak >= MAX_WAIT) m_stall = 1;
          end else m_streak = 0;
        end else if (!b_valid_i || e_rdy) begin
          m_stall = 0; m_streak = 0;
        end
        if (e_rdy) b_pend = 0;
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    raddr_a2_i = '0; raddr_b2_i = '0; rdata_a2_i = '0; rdata_b2_i = '0;
    @(negedge clk);
    test_reset();
    test_a_only();
    test_conflict();
    test_starvation();
    test_same_addr();
    test_x0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
